unidade_emissao: RTL and testbench
==================================

# unidade_emissao

Issue stage of the Tomasulo core, directly downstream of the instruction queue. It accepts one 16-bit instruction at a time from the queue and decodes it. It looks up source operands in the register file and in its own register status table, then dispatches the instruction to a free reservation station in the add or mul group. It snoops the common data bus (CDB) to clear pending tags and to forward results that arrive on the issue edge.

## Interface
- NUM_RS_ADD, default 3: number of add/sub reservation stations.
- NUM_RS_MUL, default 2: number of mul/div reservation stations. Constraint: NUM_RS_ADD+NUM_RS_MUL <= 7.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- instrucao  in  16  from the queue. Fields: [15:13] offset (ignored), [12:10] Rz (destination), [9:7] Rx, [6:4] Ry, [3:0] opcode.
- instrucaoValida  in  1  queue's output-valid.
- disponibilidade  out  1  to the queue; high when this block can accept an instruction.
- rsAddOcupada  in  NUM_RS_ADD  busy bit per add station.
- rsMulOcupada  in  NUM_RS_MUL  busy bit per mul station.
- regLeituraX, regLeituraY  out  3  register-file read addresses; combinational from the held Rx/Ry.
- valorX, valorY  in  16  register-file read data.
- cdbValido  in  1  CDB broadcast valid.
- cdbTag  in  3  CDB producing-station tag.
- cdbValor  in  16  CDB result value.
- despachoValido  out  1  one-cycle dispatch strobe.
- despachoTag  out  3  target station tag.
- despachoOpcode  out  4  opcode of the dispatched instruction.
- despachoDestino  out  3  Rz of the dispatched instruction.
- Vj, Vk  out  16  operand values from Rx and Ry.
- Qj, Qk  out  3  pending-producer tags; 0 means the operand value is valid.
- erroOpcode  out  1  one-cycle pulse when an illegal instruction is dropped.

## Operation
- Tags: 0 = no producer. Add stations use tags 1..NUM_RS_ADD. Mul stations use tags NUM_RS_ADD+1..NUM_RS_ADD+NUM_RS_MUL.
- Opcode decode:
  - 0000 ADD and 0001 SUB go to the add group.
  - 0100 MUL and 0101 DIV go to the mul group.
  - All other opcodes are illegal.
- Register status table: Qi[0..7], 3 bits each, all 0 at reset.
- FSM states:
  - VAZIO: disponibilidade=1. An edge with instrucaoValida=1 latches instrucao and moves to PRONTO.
  - PRONTO: disponibilidade=0.
    - Illegal opcode: pulse erroOpcode, leave Qi unchanged, go to VAZIO.
    - Target group has a free station: issue, go to VAZIO. The free station is the lowest-index clear busy bit.
    - Target group full: hold the instruction, no outputs change, stay in PRONTO.
- Issue edge, Rx→(Vj,Qj) and Ry→(Vk,Qk):
  - If Qi[src]=0: V=valor, Q=0.
  - Else if cdbValido and cdbTag=Qi[src]: V=cdbValor, Q=0.
  - Otherwise: V=0, Q=Qi[src].
  - Sources are read before the destination update. ADD R6,R6,R5 therefore sees the old Qi[6].
- Destination update: Qi[Rz] <= chosen tag.
- CDB clear, every edge: each r with cdbValido and Qi[r]=cdbTag gets Qi[r] <= 0. When r equals the Rz issued on the same edge, the issue write wins.
- Reset mid-operation: the held instruction is discarded, the FSM goes to VAZIO, Qi is cleared, and all outputs are deasserted immediately.

## Timing
- Reset values:
  - disponibilidade=1.
  - despachoValido=0, erroOpcode=0.
  - despachoTag, despachoOpcode, despachoDestino, Vj, Vk, Qj, Qk all 0.
  - regLeituraX/Y=0.
- Latency:
  - Capture at edge k. Dispatch outputs are registered at edge k+1 and valid during cycle k+1.
  - despachoValido is high for exactly one cycle. Peak throughput is one instruction per 2 cycles.
  - Dispatch payload holds its last value while despachoValido=0.
- Reservation-station obligation: a station must show its busy bit by the edge following despachoValido. The next issue edge is no earlier than k+3.
- erroOpcode asserts at edge k+1 for one cycle.
- Stall: while in PRONTO the block retries every edge. Release of a busy bit at edge m gives dispatch at edge m+1.

## Test plan
- Issue with ready operands: reset, then feed 0x0CA0 (ADD R3,R1,R2) with valorX=5, valorY=7, all stations free → one cycle after capture, despachoValido=1, tag=1, opcode=0, Vj=5, Vk=7, Qj=Qk=0, destino=3; Qi[3]=1.
- Dependency tracking: then feed 0x1591 (SUB R5,R3,R1) with rsAddOcupada=001 → tag=2, Qj=1, Vj=0, Vk=valorX(R1) value, Qk=0; Qi[5]=2.
- CDB forward on issue edge: repeat the previous case with cdbValido=1, cdbTag=1, cdbValor=0x0008 on the issue edge → Qj=0, Vj=8; Qi[3]=0 afterwards.
- Structural stall: rsMulOcupada=11, feed 0x1AC4 (MUL R6,R5,R4) → disponibilidade=0 and no dispatch for 5 cycles; clear bit0 → dispatch next edge with tag=4, and disponibilidade=1 again.
- Illegal opcode and destination collision:
  - Feed 0x000F → erroOpcode pulses 1 cycle, no dispatch, Qi unchanged.
  - Issue into Rz=3 while CDB clears the old Qi[3] tag on the same edge → Qi[3] = new tag.
- Asynchronous reset mid-stall: assert reset while in PRONTO → disponibilidade=1 and despachoValido=0 without waiting for a clock; all Qi=0; no dispatch of the discarded instruction after reset release.

Source files
------------

// File: rtl/unidade_emissao.sv
// unidade_emissao: Tomasulo issue stage - decode, operand/tag lookup, dispatch to free reservation station
module unidade_emissao #(
  parameter int NUM_RS_ADD = 3,
  parameter int NUM_RS_MUL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           instrucao,
  input  logic                  instrucaoValida,
  output logic                  disponibilidade,
  input  logic [NUM_RS_ADD-1:0] rsAddOcupada,
  input  logic [NUM_RS_MUL-1:0] rsMulOcupada,
  output logic [2:0]            regLeituraX,
  output logic [2:0]            regLeituraY,
  input  logic [15:0]           valorX,
  input  logic [15:0]           valorY,
  input  logic                  cdbValido,
  input  logic [2:0]            cdbTag,
  input  logic [15:0]           cdbValor,
  output logic                  despachoValido,
  output logic [2:0]            despachoTag,
  output logic [3:0]            despachoOpcode,
  output logic [2:0]            despachoDestino,
  output logic [15:0]           Vj,
  output logic [15:0]           Vk,
  output logic [2:0]            Qj,
  output logic [2:0]            Qk,
  output logic                  erroOpcode
);
  typedef enum logic {VAZIO, PRONTO} estado_t;
  estado_t         estado_q, estado_d;
  logic [12:0]     instr_q, instr_d;
  logic [7:0][2:0] qi_q, qi_d;
  logic            valido_q, valido_d, erro_q, erro_d;
  logic [2:0]      tag_q, tag_d, destino_q, destino_d, qj_q, qj_d, qk_q, qk_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [15:0]     vj_q, vj_d, vk_q, vk_d;
  logic [2:0]      rz, rx, ry, qi_x, qi_y, tag_add, tag_mul, tag_livre;
  logic [3:0]      op;
  logic            eh_add, eh_mul, livre_add, livre_mul, pronto, emite, ilegal, fwd_x, fwd_y;
  logic            unused_offset;

  assign unused_offset   = ^instrucao[15:13];
  assign {rz, rx, ry, op} = instr_q;
  assign regLeituraX     = rx;
  assign regLeituraY     = ry;
  assign eh_add          = op[3:1] == 3'b000;
  assign eh_mul          = op[3:1] == 3'b010;
  assign pronto          = estado_q == PRONTO;
  assign disponibilidade = !pronto;
  assign qi_x            = qi_q[rx];
  assign qi_y            = qi_q[ry];
  assign fwd_x           = cdbValido && cdbTag == qi_x;
  assign fwd_y           = cdbValido && cdbTag == qi_y;
  assign tag_livre       = eh_add ? tag_add : tag_mul;
  assign emite           = pronto && ((eh_add && livre_add) || (eh_mul && livre_mul));
  assign ilegal          = pronto && !eh_add && !eh_mul;

  // lowest-index free station of each group; scanning downward lets the lowest index win
  always_comb begin
    livre_add = 1'b0;
    tag_add   = 3'd0;
    livre_mul = 1'b0;
    tag_mul   = 3'd0;
    for (int i = NUM_RS_ADD - 1; i >= 0; i--)
      if (!rsAddOcupada[i]) begin
        livre_add = 1'b1;
        tag_add   = 3'(i + 1);
      end
    for (int i = NUM_RS_MUL - 1; i >= 0; i--)
      if (!rsMulOcupada[i]) begin
        livre_mul = 1'b1;
        tag_mul   = 3'(NUM_RS_ADD + i + 1);
      end
  end

  // next state: FSM, held instruction, dispatch payload and register status table
  always_comb begin
    estado_d  = pronto ? ((emite || ilegal) ? VAZIO : PRONTO) : (instrucaoValida ? PRONTO : VAZIO);
    instr_d   = (!pronto && instrucaoValida) ? instrucao[12:0] : instr_q;
    valido_d  = emite;
    erro_d    = ilegal;
    tag_d     = emite ? tag_livre : tag_q;
    opcode_d  = emite ? op : opcode_q;
    destino_d = emite ? rz : destino_q;
    vj_d      = emite ? (qi_x == 3'd0 ? valorX : fwd_x ? cdbValor : 16'd0) : vj_q;
    vk_d      = emite ? (qi_y == 3'd0 ? valorY : fwd_y ? cdbValor : 16'd0) : vk_q;
    qj_d      = emite ? ((qi_x == 3'd0 || fwd_x) ? 3'd0 : qi_x) : qj_q;
    qk_d      = emite ? ((qi_y == 3'd0 || fwd_y) ? 3'd0 : qi_y) : qk_q;
    for (int r = 0; r < 8; r++)
      qi_d[r] = (cdbValido && qi_q[r] == cdbTag) ? 3'd0 : qi_q[r];
    if (emite)
      qi_d[rz] = tag_livre;
  end

  // state registers; reset discards the held instruction and clears all tags and outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= VAZIO;
      instr_q   <= '0;
      qi_q      <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      tag_q     <= '0;
      opcode_q  <= '0;
      destino_q <= '0;
      vj_q      <= '0;
      vk_q      <= '0;
      qj_q      <= '0;
      qk_q      <= '0;
    end else begin
      estado_q  <= estado_d;
      instr_q   <= instr_d;
      qi_q      <= qi_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
      tag_q     <= tag_d;
      opcode_q  <= opcode_d;
      destino_q <= destino_d;
      vj_q      <= vj_d;
      vk_q      <= vk_d;
      qj_q      <= qj_d;
      qk_q      <= qk_d;
    end
  end

  assign despachoValido  = valido_q;
  assign erroOpcode      = erro_q;
  assign despachoTag     = tag_q;
  assign despachoOpcode  = opcode_q;
  assign despachoDestino = destino_q;
  assign Vj              = vj_q;
  assign Vk              = vk_q;
  assign Qj              = qj_q;
  assign Qk              = qk_q;
endmodule

// File: tb/tb_unidade_emissao.sv
// tb_unidade_emissao: directed plus randomized check of the issue stage against a behavioural model
module tb_unidade_emissao;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instrucao = '0;
  logic        instrucaoValida = 1'b0;
  logic [2:0]  rsAdd = '0;
  logic [1:0]  rsMul = '0;
  logic [15:0] valorX, valorY;
  logic        cdbValido = 1'b0;
  logic [2:0]  cdbTag = '0;
  logic [15:0] cdbValor = '0;
  logic        disponibilidade, despachoValido, erroOpcode;
  logic [2:0]  regLeituraX, regLeituraY, despachoTag, despachoDestino, Qj, Qk;
  logic [3:0]  despachoOpcode;
  logic [15:0] Vj, Vk;
  logic [15:0] rf [8];
  int          checks = 0;
  int          errors = 0;
  bit          m_cheio;
  logic [15:0] m_instr;
  logic [2:0]  m_qi [8];
  logic        e_disp, e_val, e_err;
  logic [2:0]  e_tag, e_dest, e_qj, e_qk;
  logic [3:0]  e_op;
  logic [15:0] e_vj, e_vk;
  logic [3:0]  ops [4];

  unidade_emissao #(.NUM_RS_ADD(3), .NUM_RS_MUL(2)) dut (
    .clock(clock), .reset(reset), .instrucao(instrucao), .instrucaoValida(instrucaoValida),
    .disponibilidade(disponibilidade), .rsAddOcupada(rsAdd), .rsMulOcupada(rsMul),
    .regLeituraX(regLeituraX), .regLeituraY(regLeituraY), .valorX(valorX), .valorY(valorY),
    .cdbValido(cdbValido), .cdbTag(cdbTag), .cdbValor(cdbValor),
    .despachoValido(despachoValido), .despachoTag(despachoTag), .despachoOpcode(despachoOpcode),
    .despachoDestino(despachoDestino), .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk), .erroOpcode(erroOpcode)
  );

  always #5 clock = ~clock;
  assign valorX = rf[regLeituraX];
  assign valorY = rf[regLeituraY];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelo_reset();
    m_cheio = 0;
    m_instr = '0;
    foreach (m_qi[r]) m_qi[r] = '0;
    {e_val, e_err, e_tag, e_dest, e_qj, e_qk, e_op, e_vj, e_vk} = '0;
    e_disp = 1'b1;
  endtask

  task automatic resolve(input int s, output logic [15:0] v, output logic [2:0] q);
    if (m_qi[s] == 0) begin v = rf[s]; q = 0; end
    else if (cdbValido && cdbTag == m_qi[s]) begin v = cdbValor; q = 0; end
    else begin v = 0; q = m_qi[s]; end
  endtask

  task automatic modelo();
    logic [2:0] novo [8];
    int op, rz, rx, ry, t;
    e_val = 0;
    e_err = 0;
    foreach (novo[r]) novo[r] = (cdbValido && m_qi[r] == cdbTag) ? 3'd0 : m_qi[r];
    if (m_cheio) begin
      op = int'(m_instr[3:0]);
      rz = int'(m_instr[12:10]);
      rx = int'(m_instr[9:7]);
      ry = int'(m_instr[6:4]);
      t = 0;
      if (op == 0 || op == 1) begin
        for (int i = 0; i < 3; i++) if (t == 0 && !rsAdd[i]) t = i + 1;
      end else if (op == 4 || op == 5) begin
        for (int i = 0; i < 2; i++) if (t == 0 && !rsMul[i]) t = 4 + i;
      end else begin
        e_err = 1;
        m_cheio = 0;
      end
      if (t != 0) begin
        resolve(rx, e_vj, e_qj);
        resolve(ry, e_vk, e_qk);
        e_val = 1;
        e_tag = 3'(t);
        e_op = 4'(op);
        e_dest = 3'(rz);
        novo[rz] = 3'(t);
        m_cheio = 0;
      end
    end else if (instrucaoValida) begin
      m_cheio = 1;
      m_instr = instrucao;
    end
    m_qi = novo;
    e_disp = !m_cheio;
  endtask

  task automatic verificar();
    check("disp", int'(disponibilidade), int'(e_disp));
    check("valido", int'(despachoValido), int'(e_val));
    check("erro", int'(erroOpcode), int'(e_err));
    check("tag", int'(despachoTag), int'(e_tag));
    check("opcode", int'(despachoOpcode), int'(e_op));
    check("destino", int'(despachoDestino), int'(e_dest));
    check("vj", int'(Vj), int'(e_vj));
    check("vk", int'(Vk), int'(e_vk));
    check("qj", int'(Qj), int'(e_qj));
    check("qk", int'(Qk), int'(e_qk));
    check("regx", int'(regLeituraX), int'(m_instr[9:7]));
    check("regy", int'(regLeituraY), int'(m_instr[6:4]));
  endtask

  task automatic passo();
    modelo();
    @(posedge clock);
    #1;
    verificar();
    @(negedge clock);
  endtask

  task automatic envia(input logic [15:0] ins);
    instrucao = ins;
    instrucaoValida = 1;
    passo();
    instrucaoValida = 0;
    passo();
  endtask

  initial begin
    ops = '{4'd0, 4'd1, 4'd4, 4'd5};
    foreach (rf[i]) rf[i] = 16'(16'h100 + i);
    rf[1] = 16'd5;
    rf[2] = 16'd7;
    modelo_reset();
    repeat (2) @(negedge clock);
    check("rst_disp", int'(disponibilidade), 1);
    check("rst_valido", int'(despachoValido), 0);
    check("rst_erro", int'(erroOpcode), 0);
    check("rst_payload", int'({despachoTag, despachoOpcode, despachoDestino, Qj, Qk}), 0);
    check("rst_v", int'({Vj, Vk}), 0);
    check("rst_reg", int'({regLeituraX, regLeituraY}), 0);
    reset = 0;
    envia(16'h0CA0);
    check("t1_valido", int'(despachoValido), 1);
    check("t1_tag", int'(despachoTag), 1);
    check("t1_op", int'(despachoOpcode), 0);
    check("t1_vj", int'(Vj), 5);
    check("t1_vk", int'(Vk), 7);
    check("t1_q", int'({Qj, Qk}), 0);
    check("t1_dest", int'(despachoDestino), 3);
    rsAdd = 3'b001;
    envia(16'h1591);
    check("t2_tag", int'(despachoTag), 2);
    check("t2_qj", int'(Qj), 1);
    check("t2_vj", int'(Vj), 0);
    check("t2_vk", int'(Vk), 5);
    check("t2_qk", int'(Qk), 0);
    instrucao = 16'h1591;
    instrucaoValida = 1;
    passo();
    instrucaoValida = 0;
    cdbValido = 1;
    cdbTag = 3'd1;
    cdbValor = 16'h0008;
    passo();
    cdbValido = 0;
    check("t3_qj", int'(Qj), 0);
    check("t3_vj", int'(Vj), 8);
    envia(16'h01B0);
    check("t3_qi3_qj", int'(Qj), 0);
    check("t3_qi3_vj", int'(Vj), int'(rf[3]));
    rsMul = 2'b11;
    instrucao = 16'h1AC4;
    instrucaoValida = 1;
    passo();
    instrucaoValida = 0;
    for (int i = 0; i < 5; i++) begin
      passo();
      check("t4_stall_disp", int'(disponibilidade), 0);
      check("t4_stall_valido", int'(despachoValido), 0);
    end
    rsMul = 2'b10;
    passo();
    check("t4_valido", int'(despachoValido), 1);
    check("t4_tag", int'(despachoTag), 4);
    check("t4_qj", int'(Qj), 2);
    check("t4_disp", int'(disponibilidade), 1);
    envia(16'h000F);
    check("t5_erro", int'(erroOpcode), 1);
    check("t5_valido", int'(despachoValido), 0);
    passo();
    check("t5_erro_fim", int'(erroOpcode), 0);
    rsMul = 2'b00;
    envia(16'h0404);
    check("t5_qi0_qj", int'(Qj), 2);
    check("t5_qi0_qk", int'(Qk), 2);
    rsAdd = 3'b000;
    envia(16'h0C00);
    check("t6_tag", int'(despachoTag), 1);
    rsAdd = 3'b001;
    instrucao = 16'h0C90;
    instrucaoValida = 1;
    passo();
    instrucaoValida = 0;
    cdbValido = 1;
    cdbTag = 3'd1;
    cdbValor = 16'h1234;
    passo();
    cdbValido = 0;
    check("t6_tag2", int'(despachoTag), 2);
    envia(16'h01B4);
    check("t6_col_qj", int'(Qj), 2);
    check("t6_col_qk", int'(Qk), 2);
    rsMul = 2'b11;
    instrucao = 16'h1AC4;
    instrucaoValida = 1;
    passo();
    instrucaoValida = 0;
    passo();
    #2 reset = 1;
    #1;
    check("t7_disp_async", int'(disponibilidade), 1);
    check("t7_valido_async", int'(despachoValido), 0);
    modelo_reset();
    verificar();
    @(negedge clock);
    reset = 0;
    rsMul = 2'b00;
    for (int i = 0; i < 3; i++) begin
      passo();
      check("t7_sem_despacho", int'(despachoValido), 0);
    end
    rsAdd = 3'b000;
    envia(16'h0330);
    check("t7_tag", int'(despachoTag), 1);
    check("t7_q", int'({Qj, Qk}), 0);
    check("t7_vj", int'(Vj), int'(rf[6]));
    check("t7_vk", int'(Vk), int'(rf[3]));
    rsAdd = '0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(3) == 0) begin
        int s;
        s = int'($urandom_range(4));
        if (s < 3) rsAdd[s] = 0; else rsMul[s-3] = 0;
      end
      if (e_val) begin
        int t;
        t = int'(e_tag);
        if (t <= 3) rsAdd[t-1] = 1; else rsMul[t-4] = 1;
      end
      cdbValido = $urandom_range(2) == 0;
      cdbTag = 3'($urandom_range(5, 1));
      cdbValor = 16'($urandom);
      instrucaoValida = 1'($urandom_range(1));
      instrucao = {3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   $urandom_range(9) < 8 ? ops[$urandom_range(3)] : 4'($urandom)};
      if ($urandom_range(7) == 0) rf[$urandom_range(7)] = 16'($urandom);
      passo();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
